// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
// Holds the state encodings of the RX and loader FSMs.
package loader_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int HDR_BYTES      = 2;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        L_CNT0,
        L_CNT1,
        L_DATA,
        L_DONE,
        L_ERR
    } ld_state_t;

endpackage

// File: rtl/uart_prog_loader_rx.sv
// 8N1 UART receiver: two-flop synchronizer plus a mid-bit sampling FSM.
// Emits one-cycle byte_valid or frame_err pulses per received frame.
module uart_rx_core
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic                      byte_valid,
    output logic [UART_DATA_BITS-1:0] byte_data,
    output logic                      frame_err
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(UART_DATA_BITS);
    localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

    logic                      rx_meta;
    logic                      rx_sync;
    rx_state_t                 state, state_n;
    logic [BAUD_W-1:0]         baud_cnt, baud_n;
    logic [BIT_W-1:0]          bit_cnt, bit_n;
    logic [UART_DATA_BITS-1:0] shreg, shreg_n;
    logic                      valid_n;
    logic                      ferr_n;

    assign byte_data = shreg;

    // Bring the asynchronous line into the clock domain; idle level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // FSM state, counters, shift register and registered pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RX_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_n;
            bit_cnt    <= bit_n;
            shreg      <= shreg_n;
            byte_valid <= valid_n;
            frame_err  <= ferr_n;
        end
    end

    // Next-state logic: sample mid-start, then once per bit period.
    always_comb begin
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        unique case (state)
            RX_IDLE: begin
                if (!rx_sync) begin
                    state_n = RX_START;
                    baud_n  = '0;
                    bit_n   = '0;
                end
            end
            RX_START: begin
                if (baud_cnt == HALF_LAST) begin
                    baud_n  = '0;
                    state_n = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (baud_cnt == FULL_LAST) begin
                    baud_n  = '0;
                    shreg_n = {rx_sync, shreg[UART_DATA_BITS-1:1]};
                    bit_n   = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        state_n = RX_STOP;
                    end
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (baud_cnt == FULL_LAST) begin
                    baud_n  = '0;
                    state_n = RX_IDLE;
                    valid_n = rx_sync;
                    ferr_n  = !rx_sync;
                end else begin
                    baud_n = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_n = RX_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: takes a length-prefixed image over UART, writes it into
// instruction memory as little-endian words, then releases the CPU.
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 14
) (
    input  logic              clk_hw,
    input  logic              rst,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam int CNT_W = HDR_BYTES * UART_DATA_BITS;
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

    logic                      byte_valid;
    logic [UART_DATA_BITS-1:0] byte_data;
    logic                      frame_err;

    ld_state_t         state, state_n;
    logic [CNT_W-1:0]  count, count_n;
    logic [ADDR_W:0]   word_idx, word_idx_n;
    logic [1:0]        byte_idx, byte_idx_n;
    logic [31:0]       word, word_n;
    logic              we_n;
    logic [ADDR_W-1:0] addr_n;
    logic [31:0]       wdata_n;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk_hw),
        .rst       (rst),
        .rx        (uart_rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    // Loader state, word assembly and the write port registers.
    always_ff @(posedge clk_hw or posedge rst) begin
        if (rst) begin
            state      <= L_CNT0;
            count      <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            word       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            word_idx   <= word_idx_n;
            byte_idx   <= byte_idx_n;
            word       <= word_n;
            imem_we    <= we_n;
            imem_addr  <= addr_n;
            imem_wdata <= wdata_n;
        end
    end

    // Status flags follow the terminal states one cycle after entry.
    always_ff @(posedge clk_hw or posedge rst) begin
        if (rst) begin
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            cpu_hold  <= (state != L_DONE);
            load_done <= (state == L_DONE);
            load_err  <= (state == L_ERR);
        end
    end

    // Header parsing, byte packing and write generation.
    always_comb begin
        state_n    = state;
        count_n    = count;
        word_idx_n = word_idx;
        byte_idx_n = byte_idx;
        word_n     = word;
        we_n       = 1'b0;
        addr_n     = imem_addr;
        wdata_n    = imem_wdata;
        unique case (state)
            L_CNT0: begin
                if (frame_err) begin
                    state_n = L_ERR;
                end else if (byte_valid) begin
                    count_n[UART_DATA_BITS-1:0] = byte_data;
                    state_n = L_CNT1;
                end
            end
            L_CNT1: begin
                if (frame_err) begin
                    state_n = L_ERR;
                end else if (byte_valid) begin
                    count_n = {byte_data, count[UART_DATA_BITS-1:0]};
                    if (32'(count_n) > MAX_WORDS) begin
                        state_n = L_ERR;
                    end else if (count_n == '0) begin
                        state_n = L_DONE;
                    end else begin
                        state_n    = L_DATA;
                        word_idx_n = '0;
                        byte_idx_n = '0;
                    end
                end
            end
            L_DATA: begin
                if (frame_err) begin
                    state_n = L_ERR;
                end else if (byte_valid) begin
                    word_n[{byte_idx, 3'b000} +: 8] = byte_data;
                    byte_idx_n = byte_idx + 1'b1;
                    if (byte_idx == 2'd3) begin
                        we_n       = 1'b1;
                        addr_n     = word_idx[ADDR_W-1:0];
                        wdata_n    = word_n;
                        word_idx_n = word_idx + 1'b1;
                        if (32'(word_idx_n) == 32'(count)) begin
                            state_n = L_DONE;
                        end
                    end
                end
            end
            L_DONE: begin
                state_n = L_DONE;
            end
            L_ERR: begin
                state_n = L_ERR;
            end
            default: begin
                state_n = L_ERR;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader with a 4-clock bit period.
// Table of images plus hand-written framing, glitch and reset sequences.
module tb_uart_prog_loader;

    localparam int CPB = 4;
    localparam int AW  = 4;

    logic          clk_hw = 1'b0;
    logic          rst = 1'b1;
    logic          uart_rx = 1'b1;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_err;

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW)
    ) dut (
        .clk_hw    (clk_hw),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk_hw = ~clk_hw;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    int          wr_n = 0;
    int          bv_cnt = 0;
    logic        prev_bv = 1'b0;
    logic        prev_we = 1'b0;

    typedef struct {
        logic [95:0] img;
        int          nb;
        int          nw;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        done;
        logic        err;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Log every write and check its latency and one-cycle width.
    always @(negedge clk_hw) begin
        if (!rst) begin
            if (dut.byte_valid) bv_cnt++;
            if (imem_we) begin
                check("we_latency", 32'(prev_bv), 32'd1);
                check("we_width", 32'(prev_we), 32'd0);
                if (wr_n < 64) begin
                    wr_addr[wr_n] = 32'(imem_addr);
                    wr_data[wr_n] = imem_wdata;
                end
                wr_n++;
            end
        end
        prev_bv = dut.byte_valid;
        prev_we = imem_we;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_hw);
        #1;
    endtask

    task automatic send_bit(input logic v);
        uart_rx = v;
        tick(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        send_bit(1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        uart_rx = 1'b1;
        tick(3);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        rst = 1'b0;
        wr_n = 0;
        bv_cnt = 0;
        tick(2);
    endtask

    task automatic check_status(input string tag, input logic done,
                                input logic err);
        check({tag, "_done"}, 32'(load_done), 32'(done));
        check({tag, "_err"}, 32'(load_err), 32'(err));
        check({tag, "_hold"}, 32'(cpu_hold), 32'(!done));
    endtask

    initial begin
        logic [95:0] img;
        logic [31:0] exp_w;

        tbl[0] = '{img: 96'h02_00_13_05_10_00_93_05_20_00, nb: 10,
                   nw: 2, d0: 32'h00100513, d1: 32'h00200593,
                   done: 1'b1, err: 1'b0};
        tbl[1] = '{img: 96'h00_00, nb: 2, nw: 0, d0: 32'h0,
                   d1: 32'h0, done: 1'b1, err: 1'b0};
        tbl[2] = '{img: 96'h11_00, nb: 2, nw: 0, d0: 32'h0,
                   d1: 32'h0, done: 1'b0, err: 1'b1};
        tbl[3] = '{img: 96'h01_00_AA_BB_CC_DD, nb: 6, nw: 1,
                   d0: 32'hDDCCBBAA, d1: 32'h0, done: 1'b1,
                   err: 1'b0};
        tbl[4] = '{img: 96'h00_01, nb: 2, nw: 0, d0: 32'h0,
                   d1: 32'h0, done: 1'b0, err: 1'b1};
        tbl[5] = '{img: 96'h01_00_01_02_03_04_05, nb: 7, nw: 1,
                   d0: 32'h04030201, d1: 32'h0, done: 1'b1,
                   err: 1'b0};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            img = tbl[v].img;
            for (int k = 0; k < tbl[v].nb; k++) begin
                send_byte(img[8*(tbl[v].nb-1-k) +: 8], 1'b1);
            end
            tick(10);
            @(negedge clk_hw);
            check($sformatf("v%0d_nwr", v), 32'(wr_n), 32'(tbl[v].nw));
            if (tbl[v].nw > 0 && wr_n > 0) begin
                check($sformatf("v%0d_a0", v), wr_addr[0], 32'd0);
                check($sformatf("v%0d_d0", v), wr_data[0], tbl[v].d0);
            end
            if (tbl[v].nw > 1 && wr_n > 1) begin
                check($sformatf("v%0d_a1", v), wr_addr[1], 32'd1);
                check($sformatf("v%0d_d1", v), wr_data[1], tbl[v].d1);
            end
            check_status($sformatf("v%0d", v), tbl[v].done, tbl[v].err);
        end

        // Maximum-size image: 16 words fill the whole memory.
        do_reset();
        send_byte(8'h10, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int k = 0; k < 64; k++) begin
            send_byte(8'(k), 1'b1);
            if (k == 40) begin
                @(negedge clk_hw);
                check_status("max_mid", 1'b0, 1'b0);
            end
        end
        tick(10);
        @(negedge clk_hw);
        check("max_nwr", 32'(wr_n), 32'd16);
        for (int w = 0; w < 16 && w < wr_n; w++) begin
            exp_w = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
            check($sformatf("max_a%0d", w), wr_addr[w], 32'(w));
            check($sformatf("max_d%0d", w), wr_data[w], exp_w);
        end
        check_status("max", 1'b1, 1'b0);

        // Bad stop bit in the middle of a word, then valid bytes.
        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b1);
        tick(10);
        @(negedge clk_hw);
        check("ferr_nwr", 32'(wr_n), 32'd0);
        check_status("ferr", 1'b0, 1'b1);

        // One-cycle low glitch while idle between header and data.
        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        tick(4);
        uart_rx = 1'b0;
        tick(1);
        uart_rx = 1'b1;
        tick(20);
        @(negedge clk_hw);
        check("glitch_bv", 32'(bv_cnt), 32'd2);
        check("glitch_state", 32'(dut.state), 32'(loader_pkg::L_DATA));
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        tick(10);
        @(negedge clk_hw);
        check("glitch_nwr", 32'(wr_n), 32'd1);
        check("glitch_d0", wr_data[0], 32'hDDCCBBAA);
        check_status("glitch", 1'b1, 1'b0);

        // Reset after five data bytes, then a fresh one-word image.
        do_reset();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        send_byte(8'h55, 1'b1);
        tick(4);
        @(negedge clk_hw);
        check("mid_nwr", 32'(wr_n), 32'd1);
        check("mid_d0", wr_data[0], 32'h44332211);
        check_status("mid", 1'b0, 1'b0);
        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        tick(10);
        @(negedge clk_hw);
        check("rerun_nwr", 32'(wr_n), 32'd1);
        if (wr_n > 0) begin
            check("rerun_a0", wr_addr[0], 32'd0);
            check("rerun_d0", wr_data[0], 32'hDDCCBBAA);
        end
        check_status("rerun", 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Boot-time program loader that sits upstream of the CPU core inside `main`.
- Receives a program image over UART, assembles little-endian 32-bit words and writes them into instruction memory.
- Holds the CPU in reset until the image is complete, then releases it.
- Lets the board run new programs without re-synthesis; simulation benches drive `uart_rx` directly.

Parameters:
- CLKS_PER_BIT, 868, clk_hw cycles per UART bit (115200 baud at 100 MHz); minimum 4.
- ADDR_W, 14, instruction-memory word-address width; maximum image is 2^ADDR_W words.

Ports:
- clk_hw  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- uart_rx  in  1  serial input, idle high, 8N1, LSB first; asynchronous to clk_hw.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  word to write.
- cpu_hold  out  1  high keeps the CPU core in reset.
- load_done  out  1  high once the full image has been written; sticky.
- load_err  out  1  framing or size error; sticky until rst.

Behaviour:
- Reset values:
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_hold=1, load_done=0, load_err=0.
  - Both FSMs go to their idle state; the synchronizer flops reset to 1.
- Reset asserted mid-transfer aborts everything; the next image must restart from the header.
- RX synchronizer: 2 flops on uart_rx. All RX logic uses the synchronized value.
- RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE: on synced rx==0, go to RX_START and clear the bit counter.
  - RX_START: wait CLKS_PER_BIT/2 cycles (integer divide), then sample.
    - rx==1: glitch; return to RX_IDLE and emit nothing.
    - rx==0: go to RX_DATA.
  - RX_DATA: every CLKS_PER_BIT cycles, sample one bit into the shift register, LSB first. After 8 bits go to RX_STOP.
  - RX_STOP: after CLKS_PER_BIT cycles, sample.
    - rx==1: pulse byte_valid for 1 cycle with the byte.
    - rx==0: pulse frame_err for 1 cycle.
    - Either way return to RX_IDLE.
- Loader FSM states: L_CNT0, L_CNT1, L_DATA, L_DONE, L_ERR. Acts only on byte_valid / frame_err pulses.
  - L_CNT0: byte becomes count[7:0]; go to L_CNT1.
  - L_CNT1: byte becomes count[15:8]. Evaluate the 16-bit count in this order:
    - count > 2^ADDR_W: go to L_ERR.
    - count == 0: go to L_DONE.
    - otherwise: go to L_DATA with word_idx=0 and byte_idx=0.
  - L_DATA:
    - Each byte is placed in word bits [8*byte_idx+7 : 8*byte_idx]; byte_idx increments and wraps 3→0.
    - On the byte with byte_idx==3, the next cycle drives imem_we=1 for exactly one cycle, with imem_addr=word_idx and imem_wdata=the assembled word.
    - word_idx then increments.
    - When word_idx reaches count, go to L_DONE.
  - frame_err in any of L_CNT0, L_CNT1 or L_DATA: go to L_ERR.
- Latency: imem_we rises 1 cycle after the byte_valid pulse of the 4th byte of a word.
- L_DONE:
  - load_done=1 and cpu_hold=0, registered, starting the cycle after entry.
  - All further UART traffic is ignored.
- L_ERR:
  - load_err=1 and cpu_hold stays 1.
  - Terminal; only rst exits.
- Counter widths:
  - Words: word_idx is ADDR_W+1 bits, so the full 2^ADDR_W count compares without wrap.
  - imem_addr carries word_idx[ADDR_W-1:0].
  - Baud counter is $clog2(CLKS_PER_BIT) bits.
- A byte arriving at the same cycle as the final write cannot occur; byte_valid is at most one per 10·CLKS_PER_BIT cycles.

Decomposition:
- Shared package loader_pkg holds:
  - the state enums for both FSMs (rx_state_t, ld_state_t);
  - the constants UART_DATA_BITS=8 and HDR_BYTES=2.
- Natural sub-module: uart_rx_core (synchronizer plus RX FSM; outputs byte_valid, byte_data, frame_err).
- The loader FSM stays in uart_prog_loader.

Test Plan (all with CLKS_PER_BIT=4, ADDR_W=4):
- Reset: hold rst for 3 cycles → imem_we=0, cpu_hold=1, load_done=0, load_err=0, imem_addr=0.
- Two-word load: send 02 00 | 13 05 10 00 | 93 05 20 00 →
  - write 1: imem_we pulses at addr 0 with 0x00100513;
  - write 2: imem_we pulses at addr 1 with 0x00200593;
  - each pulse comes 1 cycle after the last byte's stop sample;
  - load_done=1 and cpu_hold=0 on the cycle after the 2nd write.
- Zero-length image: send 00 00 → load_done=1, cpu_hold=0, no imem_we pulse ever.
- Oversize and max-size images:
  - send 11 00 (17 > 16) → load_err=1, cpu_hold stays 1, no writes.
  - send 10 00 followed by 64 bytes → 16 writes to addrs 0..15, then load_done=1.
- Framing and glitch:
  - a byte with stop bit=0 during L_DATA → load_err=1, no further imem_we even when valid bytes follow;
  - a 1-cycle low glitch on uart_rx in idle → no byte_valid, FSM unchanged.
- Reset mid-operation: assert rst after 5 data bytes → all outputs return to reset values; a fresh 01 00 AA BB CC DD then writes 0xDDCCBBAA to addr 0 and sets load_done.
